// File: rtl/mycpu_lsu.sv
// mycpu_lsu: load/store unit between EX and WB.
// Drives the data-SRAM handshake, aligns loads/stores, feeds bypass to decode.
module mycpu_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_result,
    input  logic [5:0]  in_c8,
    input  logic [31:0] in_rt,
    input  logic [4:0]  in_target,
    input  logic        in_wen,
    output logic        data_req,
    output logic        data_wr,
    output logic [31:0] data_addr,
    output logic [1:0]  data_size,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        wb_valid,
    output logic        wb_wen,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic [5:0]  bypass_tag,
    output logic [31:0] bypass_data
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] result_q, rt_q, rdata_q;
    logic [5:0]  c8_q;
    logic [4:0]  target_q;
    logic        wen_q;

    logic        accept, take_rdata;
    logic        is_load, is_store, sext;
    logic [2:0]  size;
    logic [1:0]  a;
    logic [3:0]  st_strb;
    logic [31:0] st_data, ld_data, m;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign accept   = in_valid && in_ready;
    assign is_load  = c8_q[5];
    assign is_store = c8_q[4];
    assign size     = c8_q[3:1];
    assign sext     = c8_q[0];
    assign a        = result_q[1:0];
    assign m        = rdata_q;
    assign take_rdata = (state == WAIT && data_data_ok) ||
                        (state == REQ && data_addr_ok && data_data_ok);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic for the SRAM transaction
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept)
                      state_nx = (in_c8[5:4] == 2'b00) ? DONE : REQ;
            REQ:  if (data_addr_ok)
                      state_nx = data_data_ok ? DONE : WAIT;
            WAIT: if (data_data_ok) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Holding registers for the accepted instruction and its read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            rt_q     <= '0;
            c8_q     <= '0;
            target_q <= '0;
            wen_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                result_q <= in_result;
                rt_q     <= in_rt;
                c8_q     <= in_c8;
                target_q <= in_target;
                wen_q    <= in_wen;
            end
            if (take_rdata) rdata_q <= data_rdata;
        end
    end

    // Store byte-lane strobes and lane-aligned data
    always_comb begin
        st_strb = 4'b1111;
        st_data = rt_q;
        case (size)
            3'b000: begin
                st_strb = 4'b0001 << a;
                st_data = {4{rt_q[7:0]}};
            end
            3'b001: begin
                st_strb = a[1] ? 4'b1100 : 4'b0011;
                st_data = {2{rt_q[15:0]}};
            end
            3'b011: begin
                case (a)
                    2'd0: begin st_strb = 4'b0001; st_data = {24'd0, rt_q[31:24]}; end
                    2'd1: begin st_strb = 4'b0011; st_data = {16'd0, rt_q[31:16]}; end
                    2'd2: begin st_strb = 4'b0111; st_data = {8'd0, rt_q[31:8]}; end
                    default: begin st_strb = 4'b1111; st_data = rt_q; end
                endcase
            end
            3'b100: begin
                case (a)
                    2'd0: begin st_strb = 4'b1111; st_data = rt_q; end
                    2'd1: begin st_strb = 4'b1110; st_data = {rt_q[23:0], 8'd0}; end
                    2'd2: begin st_strb = 4'b1100; st_data = {rt_q[15:0], 16'd0}; end
                    default: begin st_strb = 4'b1000; st_data = {rt_q[7:0], 24'd0}; end
                endcase
            end
            default: ;
        endcase
    end

    // Load extraction, extension and LWL/LWR merge
    always_comb begin
        ld_half = a[1] ? m[31:16] : m[15:0];
        case (a)
            2'd0:    ld_byte = m[7:0];
            2'd1:    ld_byte = m[15:8];
            2'd2:    ld_byte = m[23:16];
            default: ld_byte = m[31:24];
        endcase
        ld_data = m;
        case (size)
            3'b000: ld_data = {{24{sext & ld_byte[7]}}, ld_byte};
            3'b001: ld_data = {{16{sext & ld_half[15]}}, ld_half};
            3'b011: begin
                case (a)
                    2'd0:    ld_data = {m[7:0], rt_q[23:0]};
                    2'd1:    ld_data = {m[15:0], rt_q[15:0]};
                    2'd2:    ld_data = {m[23:0], rt_q[7:0]};
                    default: ld_data = m;
                endcase
            end
            3'b100: begin
                case (a)
                    2'd0:    ld_data = m;
                    2'd1:    ld_data = {rt_q[31:24], m[31:8]};
                    2'd2:    ld_data = {rt_q[31:16], m[31:16]};
                    default: ld_data = {rt_q[31:8], m[31:24]};
                endcase
            end
            default: ;
        endcase
    end

    // Handshake, SRAM, writeback and bypass outputs decoded from state
    always_comb begin
        in_ready    = (state == IDLE);
        data_req    = (state == REQ);
        data_wr     = 1'b0;
        data_addr   = '0;
        data_size   = 2'd0;
        data_wstrb  = 4'b0000;
        data_wdata  = '0;
        wb_valid    = (state == DONE);
        wb_wen      = 1'b0;
        wb_waddr    = '0;
        wb_wdata    = '0;
        bypass_tag  = '0;
        bypass_data = '0;
        if (state == REQ) begin
            data_wr = is_store;
            if (size == 3'b000 || size == 3'b001) begin
                data_addr = result_q;
                data_size = (size == 3'b000) ? 2'd0 : 2'd1;
            end else begin
                data_addr = {result_q[31:2], 2'b00};
                data_size = 2'd2;
            end
            if (is_store) begin
                data_wstrb = st_strb;
                data_wdata = st_data;
            end
        end
        if (state == DONE) begin
            wb_wen   = wen_q && !is_store;
            wb_waddr = target_q;
            wb_wdata = is_load ? ld_data : result_q;
        end
        if (state != IDLE) begin
            bypass_tag  = {is_load, wen_q ? target_q : 5'd0};
            bypass_data = is_load ? ((state == DONE) ? ld_data : 32'd0)
                                  : result_q;
        end
    end

endmodule

// File: tb/tb_mycpu_lsu.sv
// tb_mycpu_lsu: directed checks of mycpu_lsu.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mycpu_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [5:0]  in_c8;
    logic [31:0] in_rt;
    logic [4:0]  in_target;
    logic        in_wen;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        wb_valid;
    logic        wb_wen;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic [5:0]  bypass_tag;
    logic [31:0] bypass_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mycpu_lsu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_c8(in_c8), .in_rt(in_rt),
        .in_target(in_target), .in_wen(in_wen),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
        .data_size(data_size), .data_wstrb(data_wstrb),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_waddr(wb_waddr),
        .wb_wdata(wb_wdata), .bypass_tag(bypass_tag),
        .bypass_data(bypass_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] res, input logic [5:0] c8,
                         input logic [31:0] rt, input logic [4:0] tgt,
                         input logic wen);
        in_valid  = 1'b1;
        in_result = res;
        in_c8     = c8;
        in_rt     = rt;
        in_target = tgt;
        in_wen    = wen;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_result = '0; in_c8 = '0; in_rt = '0;
        in_target = '0; in_wen = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_req", data_req, 0);
        chk("rst_wb", wb_valid, 0);
        chk("rst_tag", bypass_tag, 0);
        rst = 1'b0;
        @(negedge clk);

        // pass-through
        issue(32'h12345678, 6'h00, 32'h0, 5'd8, 1'b1);
        chk("pt_valid", wb_valid, 1);
        chk("pt_wen", wb_wen, 1);
        chk("pt_waddr", wb_waddr, 8);
        chk("pt_wdata", wb_wdata, 32'h12345678);
        chk("pt_tag", bypass_tag, 6'h08);
        chk("pt_bpdata", bypass_data, 32'h12345678);
        chk("pt_ready", in_ready, 0);
        @(negedge clk);
        chk("pt_idle_valid", wb_valid, 0);
        chk("pt_idle_ready", in_ready, 1);

        // LB signed, addr_ok after 2 stall cycles, data_ok 3 cycles later
        issue(32'h00001003, 6'h21, 32'h0, 5'd5, 1'b1);
        chk("lb_req1", data_req, 1);
        chk("lb_addr", data_addr, 32'h00001003);
        chk("lb_size", data_size, 0);
        chk("lb_wr", data_wr, 0);
        chk("lb_strb", data_wstrb, 0);
        chk("lb_tag", bypass_tag, 6'h25);
        @(negedge clk);
        chk("lb_req2", data_req, 1);
        chk("lb_addr2", data_addr, 32'h00001003);
        @(negedge clk);
        chk("lb_req3", data_req, 1);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        chk("lb_req_drop", data_req, 0);
        chk("lb_wait_tag", bypass_tag, 6'h25);
        @(negedge clk);
        @(negedge clk);
        chk("lb_wait_valid", wb_valid, 0);
        data_data_ok = 1'b1;
        data_rdata = 32'h80FF0000;
        @(negedge clk);
        data_data_ok = 1'b0;
        data_rdata = 32'h0;
        chk("lb_valid", wb_valid, 1);
        chk("lb_wdata", wb_wdata, 32'hFFFFFF80);
        chk("lb_wen", wb_wen, 1);
        chk("lb_waddr", wb_waddr, 5);
        chk("lb_done_tag", bypass_tag, 6'h25);
        chk("lb_bpdata", bypass_data, 32'hFFFFFF80);
        @(negedge clk);
        chk("lb_idle_tag", bypass_tag, 0);
        chk("lb_idle_valid", wb_valid, 0);

        // SH at a=2
        issue(32'h00002002, 6'h12, 32'h0000BEEF, 5'd3, 1'b1);
        chk("sh_wr", data_wr, 1);
        chk("sh_size", data_size, 1);
        chk("sh_addr", data_addr, 32'h00002002);
        chk("sh_strb", data_wstrb, 4'b1100);
        chk("sh_wdata", data_wdata, 32'hBEEFBEEF);
        chk("sh_tag", bypass_tag, 6'h03);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        @(negedge clk);
        data_data_ok = 1'b0;
        chk("sh_valid", wb_valid, 1);
        chk("sh_wen", wb_wen, 0);
        @(negedge clk);

        // LWL a=1
        issue(32'h00003001, 6'h26, 32'hAABBCCDD, 5'd9, 1'b1);
        chk("lwl_addr", data_addr, 32'h00003000);
        chk("lwl_size", data_size, 2);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata = 32'h11223344;
        @(negedge clk);
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        chk("lwl_wdata", wb_wdata, 32'h3344CCDD);
        @(negedge clk);

        // LWR a=2
        issue(32'h00003002, 6'h28, 32'hAABBCCDD, 5'd10, 1'b1);
        chk("lwr_addr", data_addr, 32'h00003000);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        @(negedge clk);
        data_data_ok = 1'b0;
        chk("lwr_wdata", wb_wdata, 32'hAABB1122);
        @(negedge clk);

        // SWL a=2, same-cycle addr_ok and data_ok
        issue(32'h00004006, 6'h16, 32'hAABBCCDD, 5'd0, 1'b0);
        chk("swl_addr", data_addr, 32'h00004004);
        chk("swl_strb", data_wstrb, 4'b0111);
        chk("swl_wdata", data_wdata, 32'h00AABBCC);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        chk("swl_valid", wb_valid, 1);
        chk("swl_wen", wb_wen, 0);
        @(negedge clk);

        // SWR a=1
        issue(32'h00004005, 6'h18, 32'hAABBCCDD, 5'd0, 1'b0);
        chk("swr_strb", data_wstrb, 4'b1110);
        chk("swr_wdata", data_wdata, 32'hBBCCDD00);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        @(negedge clk);

        // reset during REQ drops data_req asynchronously
        issue(32'h00005000, 6'h24, 32'h0, 5'd4, 1'b1);
        chk("rreq_req", data_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("rreq_req_drop", data_req, 0);
        chk("rreq_ready", in_ready, 1);
        chk("rreq_tag", bypass_tag, 0);
        @(negedge clk);
        rst = 1'b0;

        // reset during WAIT; a late data_ok is ignored
        issue(32'h00005000, 6'h24, 32'h0, 5'd4, 1'b1);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        chk("rwait_tag_pre", bypass_tag, 6'h24);
        #2 rst = 1'b1;
        #1;
        chk("rwait_ready", in_ready, 1);
        chk("rwait_tag", bypass_tag, 0);
        chk("rwait_wb", wb_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        data_data_ok = 1'b1;
        data_rdata = 32'hDEADBEEF;
        @(negedge clk);
        data_data_ok = 1'b0;
        chk("rwait_late_wb", wb_valid, 0);
        chk("rwait_late_ready", in_ready, 1);
        @(negedge clk);
        chk("rwait_late_wb2", wb_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
